riscv_fetch_stage: RTL and testbench
====================================

RISCV_FETCH_STAGE -- requirements
Module: riscv_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port flush_i, input, 1, redirect request from the execute stage.
REQ-005 SHALL have port redirect_pc_i, input, 32, target PC, sampled when flush_i=1.
REQ-006 SHALL have port imem_req_o, output, 1, instruction-memory request valid.
REQ-007 SHALL have port imem_addr_o, output, 32, word address of the request.
REQ-008 SHALL have port imem_valid_i, input, 1, response strobe; arrives 1 or more cycles after acceptance.
REQ-009 SHALL have port imem_rdata_i, input, 32, instruction word, valid with imem_valid_i.
REQ-010 SHALL have port if_valid_o, output, 1, IF/ID register holds an instruction.
REQ-011 SHALL have port if_pc_o, output, 32, PC of the held instruction.
REQ-012 SHALL have port if_instr_o, output, 32, the held instruction.
REQ-013 SHALL have port id_ready_i, input, 1, decode accepts this cycle.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, DROP.
REQ-015 IDLE SHALL go to REQ one cycle after rst_n deasserts, with pc=RESET_PC.
REQ-016 In REQ, the block SHALL drive imem_req_o=1 and imem_addr_o=pc, then go to WAIT; a request is accepted in the cycle it is driven.
REQ-017 In WAIT, on imem_valid_i, the block SHALL load IF/ID (pc, imem_rdata_i) and set if_valid_o the next cycle, set pc=pc+4 with 32-bit wrap, then go to REQ.
REQ-018 The transfer to decode SHALL occur when if_valid_o and id_ready_i are both 1; if_pc_o and if_instr_o SHALL stay stable while if_valid_o=1 and id_ready_i=0.
REQ-019 The block SHALL NOT issue a request while IF/ID is full and not being drained in that cycle, so at most one response is outstanding.
REQ-020 On flush_i in REQ or IDLE, the block SHALL set pc=redirect_pc_i, clear if_valid_o, and issue no request to the old pc.
REQ-021 On flush_i in WAIT without imem_valid_i, the block SHALL go to DROP, set pc=redirect_pc_i and clear if_valid_o.
REQ-022 On flush_i in WAIT coinciding with imem_valid_i, the block SHALL discard the response, set pc=redirect_pc_i, go to REQ, and keep if_valid_o=0.
REQ-023 DROP SHALL discard the next imem_valid_i response and then go to REQ; a further flush_i in DROP SHALL overwrite pc only.
REQ-024 If flush_i and id_ready_i are both 1 in the same cycle, flush SHALL win and the held instruction is killed.
REQ-025 Single-response throughput SHALL be one instruction per 2 cycles when imem_valid_i returns 1 cycle after the request.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, if_valid_o=0, if_pc_o=0, if_instr_o=0, imem_req_o=0 and imem_addr_o=0.
REQ-027 Reset mid-transaction SHALL abandon the outstanding response; imem_valid_i arriving in IDLE SHALL be ignored.

Configuration
REQ-028 With macro FETCH_MISALIGN_TRAP_EN defined, the block SHALL add output if_misalign_o: a redirect_pc_i[1:0]!=0 SHALL produce no memory request, and SHALL load IF/ID with if_pc_o=target, if_instr_o=32'h0000_0013 (NOP), if_misalign_o=1.
REQ-029 Without FETCH_MISALIGN_TRAP_EN, the block SHALL have no if_misalign_o port and SHALL clear redirect_pc_i[1:0] to 0 before use.

Structure
REQ-030 A shared package riscv_pkg SHALL hold the FSM state typedef, the NOP encoding 32'h0000_0013, and the XLEN=32 constant.
REQ-031 The IF/ID register with its valid/ready hold logic SHALL be the sub-module riscv_if_id_reg; all else stays in riscv_fetch_stage.

Verification
REQ-032 Reset release with 1-cycle memory latency and id_ready_i=1 -> requests at 0x0, 0x4, 0x8; if_pc_o sequence 0x0, 0x4, 0x8, one instruction every 2 cycles.
REQ-033 id_ready_i=0 for 5 cycles with if_valid_o=1 -> if_pc_o and if_instr_o unchanged and no new imem_req_o; release -> fetching resumes at the next PC.
REQ-034 flush_i to 0x100 while a 3-cycle response is outstanding -> the stale word is never presented; next request is 0x100.
REQ-035 flush_i to 0x200 in the same cycle as imem_valid_i -> the response is dropped and the next imem_addr_o is 0x200.
REQ-036 pc=0xFFFF_FFFC fetch -> the next request is 0x0000_0000.
REQ-037 With FETCH_MISALIGN_TRAP_EN, flush to 0x102 -> no request, if_misalign_o=1, if_instr_o=0x0000_0013; without the macro -> the request goes to 0x100.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end: data width, the canonical
// NOP encoding and the fetch-stage FSM state type.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/riscv_if_id_reg.sv
// IF/ID pipeline register with valid/ready hand-off to decode.
// Holds pc/instr stable while valid and decode is not ready. A load always
// wins; otherwise a clear (flush) or a decode acceptance empties the register.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a misaligned-target flag.
module riscv_if_id_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic            ready,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  logic            load_misalign,
    output logic            misalign,
`endif
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    // Capture a new entry, or drop the held one on flush / decode acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            pc       <= '0;
            instr    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
        end else if (load) begin
            valid    <= 1'b1;
            pc       <= load_pc;
            instr    <= load_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign <= load_misalign;
`endif
        end else if (clear || ready) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch stage: single-outstanding-request fetch FSM
// (IDLE/REQ/WAIT/DROP) feeding the IF/ID register.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target issues
// no memory request and instead presents a NOP tagged with if_misalign_o.
// Without it, redirect targets are forced to word alignment.
module riscv_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_valid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            if_misalign_o,
`endif
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o,
    input  logic            id_ready_i
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] target;
    logic            pc_ok;
    logic            can_issue;
    logic            req;
    logic            ifid_load;
    logic            ifid_clear;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] load_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            load_misalign;
    logic            bad_target;

    // Keep the raw target; a misaligned pc simply never fetches until the
    // trap handler redirects again.
    assign target     = redirect_pc_i;
    assign bad_target = flush_i && (redirect_pc_i[1:0] != 2'b00);
    assign pc_ok      = (pc[1:0] == 2'b00);
`else
    assign target     = redirect_pc_i & {{(XLEN-2){1'b1}}, 2'b00};
    assign pc_ok      = 1'b1;
`endif

    // Only one response may be in flight: request only if IF/ID will have room
    assign can_issue   = !if_valid_o || id_ready_i;
    assign imem_req_o  = req;
    assign imem_addr_o = req ? pc : '0;

    // State and fetch pc registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Next-state, request and IF/ID control; flush overrides pc and kills IF/ID
    always_comb begin
        state_next = state;
        pc_next    = pc;
        req        = 1'b0;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        load_pc    = pc;
        load_instr = imem_rdata_i;
`ifdef FETCH_MISALIGN_TRAP_EN
        load_misalign = 1'b0;
`endif

        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (!flush_i && can_issue && pc_ok) begin
                    req        = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    // A response coinciding with the flush is stale: drop it now,
                    // otherwise wait for it in DROP.
                    state_next = imem_valid_i ? REQ : DROP;
                end else if (imem_valid_i) begin
                    ifid_load  = 1'b1;
                    pc_next    = pc + XLEN'(4);
                    state_next = REQ;
                end
            end
            DROP: begin
                if (imem_valid_i) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (flush_i) begin
            pc_next    = target;
            ifid_clear = 1'b1;
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        if (bad_target) begin
            ifid_load     = 1'b1;
            load_pc       = target;
            load_instr    = NOP_INSTR;
            load_misalign = 1'b1;
        end
`endif
    end

    riscv_if_id_reg u_if_id (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (ifid_load),
        .clear         (ifid_clear),
        .ready         (id_ready_i),
        .load_pc       (load_pc),
        .load_instr    (load_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
        .load_misalign (load_misalign),
        .misalign      (if_misalign_o),
`endif
        .valid         (if_valid_o),
        .pc            (if_pc_o),
        .instr         (if_instr_o)
    );

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Testbench for riscv_fetch_stage: behavioural instruction memory with
// programmable latency plus a scoreboard of instructions expected at IF/ID.
module tb_riscv_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        id_ready_i;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misalign_o;
`endif

    riscv_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_valid_i  (imem_valid_i),
        .imem_rdata_i  (imem_rdata_i),
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_misalign_o (if_misalign_o),
`endif
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .id_ready_i    (id_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_fail;
    int          lat;
    int          cnt;
    int          cyc;
    int          n_req;
    int          n_xfer;
    bit          pend;
    bit          stale;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    ent_t        sb[$];
    int          xfer_cyc[$];
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic [31:0] last_xfer_pc;
    logic [31:0] last_xfer_instr;
    logic        last_xfer_mis;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are sampled mid-cycle
    // and the scoreboard / address model is updated.
    task automatic cycle();
        ent_t e;
        @(negedge clk);
        imem_valid_i = 1'b0;
        imem_rdata_i = 32'h0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_valid_i = 1'b1;
                imem_rdata_i = instr_of(pend_addr);
                pend         = 1'b0;
            end
        end
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = if_valid_o;
        s_pc    = if_pc_o;
        s_instr = if_instr_o;
        if (!rst_n) begin
            sb.delete();
            exp_pc = RST_PC;
            if (imem_valid_i) stale = 1'b0;
            if (pend) stale = 1'b1;
            if (imem_req_o) begin
                pend = 1'b1; cnt = lat; pend_addr = imem_addr_o; stale = 1'b1;
            end
        end else begin
            if (if_valid_o && id_ready_i && !flush_i) begin
                e = (sb.size() > 0) ? sb.pop_front() : '{pc: 32'hDEAD_BEEF, instr: 32'hDEAD_BEEF, mis: 1'b0};
                check("xfer_pc", if_pc_o, e.pc);
                check("xfer_instr", if_instr_o, e.instr);
`ifdef FETCH_MISALIGN_TRAP_EN
                check("xfer_misalign", {31'b0, if_misalign_o}, {31'b0, e.mis});
                last_xfer_mis = if_misalign_o;
`else
                last_xfer_mis = 1'b0;
`endif
                last_xfer_pc    = if_pc_o;
                last_xfer_instr = if_instr_o;
                xfer_cyc.push_back(cyc);
                n_xfer++;
            end
            if (flush_i) sb.delete();
            if (imem_valid_i) begin
                if (!stale && !flush_i) begin
                    sb.push_back('{pc: pend_addr, instr: instr_of(pend_addr), mis: 1'b0});
                    exp_pc = pend_addr + 32'd4;
                end
                stale = 1'b0;
            end
            if (flush_i) begin
                if (pend) stale = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                exp_pc = redirect_pc_i;
                if (redirect_pc_i[1:0] != 2'b00)
                    sb.push_back('{pc: redirect_pc_i, instr: 32'h0000_0013, mis: 1'b1});
`else
                exp_pc = {redirect_pc_i[31:2], 2'b00};
`endif
            end
            if (imem_req_o) begin
                check("one_outstanding", {31'b0, pend}, 32'd0);
                check("req_addr", imem_addr_o, exp_pc);
                pend      = 1'b1;
                cnt       = lat;
                pend_addr = imem_addr_o;
                stale     = 1'b0;
                n_req++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_req(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            cycle();
            if (s_req) break;
        end
        check(tag, {31'b0, s_req}, 32'd1);
    endtask

    initial begin
        int first_req;
        int n0;
        logic [31:0] held_pc;
        logic [31:0] held_instr;

        n_chk = 0; n_fail = 0; lat = 1; cnt = 0; cyc = 0; n_req = 0; n_xfer = 0;
        pend = 1'b0; stale = 1'b0; pend_addr = '0; exp_pc = RST_PC;
        last_xfer_pc = '0; last_xfer_instr = '0; last_xfer_mis = 1'b0;
        rst_n = 1'b0; flush_i = 1'b0; redirect_pc_i = '0;
        imem_valid_i = 1'b0; imem_rdata_i = '0; id_ready_i = 1'b1;

        // Reset values
        repeat (3) cycle();
        check("rst_req", {31'b0, s_req}, 32'd0);
        check("rst_addr", s_addr, 32'd0);
        check("rst_if_valid", {31'b0, s_valid}, 32'd0);
        check("rst_if_pc", s_pc, 32'd0);
        check("rst_if_instr", s_instr, 32'd0);

        // Reset release, 1-cycle memory: 0x0, 0x4, 0x8 every 2 cycles
        rst_n = 1'b1; cyc = 0; first_req = -1; xfer_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_req && first_req < 0) first_req = cyc - 1;
        end
        check("first_req_cycle", first_req, 32'd1);
        check("xfer_count", xfer_cyc.size(), 32'd3);
        if (xfer_cyc.size() >= 3) begin
            check("first_xfer_cycle", xfer_cyc[0], 32'd3);
            check("throughput_gap0", xfer_cyc[1] - xfer_cyc[0], 32'd2);
            check("throughput_gap1", xfer_cyc[2] - xfer_cyc[1], 32'd2);
        end

        // Decode stall for 5 cycles with IF/ID full
        for (int i = 0; i < 10; i++) begin
            if (if_valid_o) break;
            cycle();
        end
        id_ready_i = 1'b0;
        held_pc    = (sb.size() > 0) ? sb[0].pc : 32'hDEAD_BEEF;
        held_instr = (sb.size() > 0) ? sb[0].instr : 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_valid", {31'b0, s_valid}, 32'd1);
            check("stall_pc", s_pc, held_pc);
            check("stall_instr", s_instr, held_instr);
            check("stall_no_req", {31'b0, s_req}, 32'd0);
        end
        id_ready_i = 1'b1;
        wait_req("resume_req", 4);
        check("resume_addr", s_addr, held_pc + 32'd4);

        // Flush to 0x100 while a 3-cycle response is outstanding
        lat = 3;
        wait_req("t3_req", 10);
        flush_i = 1'b1; redirect_pc_i = 32'h0000_0100;
        cycle();
        flush_i = 1'b0;
        wait_req("t3_req_after_flush", 12);
        check("t3_flush_addr", s_addr, 32'h0000_0100);
        n0 = n_xfer;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (n_xfer != n0) break;
        end
        check("t3_first_xfer_pc", last_xfer_pc, 32'h0000_0100);

        // Flush to 0x200 in the same cycle as the response
        lat = 2;
        for (int i = 0; i < 12; i++) begin
            if (pend && cnt == 1 && !stale) break;
            cycle();
        end
        flush_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        cycle();
        flush_i = 1'b0;
        wait_req("t4_req", 8);
        check("t4_flush_addr", s_addr, 32'h0000_0200);

        // PC wrap at the top of the address space
        lat = 1;
        flush_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        cycle();
        flush_i = 1'b0;
        wait_req("wrap_req0", 8);
        check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        wait_req("wrap_req1", 8);
        check("wrap_addr1", s_addr, 32'h0000_0000);

        // Misaligned redirect target
        flush_i = 1'b1; redirect_pc_i = 32'h0000_0102;
        cycle();
        flush_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        n0 = n_req;
        repeat (6) cycle();
        check("misalign_no_req", n_req - n0, 32'd0);
        check("misalign_xfer_pc", last_xfer_pc, 32'h0000_0102);
        check("misalign_xfer_instr", last_xfer_instr, 32'h0000_0013);
        check("misalign_flag", {31'b0, last_xfer_mis}, 32'd1);
`else
        wait_req("align_req", 8);
        check("align_addr", s_addr, 32'h0000_0100);
`endif
        flush_i = 1'b1; redirect_pc_i = 32'h0000_0300;
        cycle();
        flush_i = 1'b0;
        wait_req("t6_recover_req", 8);
        check("t6_recover_addr", s_addr, 32'h0000_0300);

        // Reset while a response is outstanding
        lat = 2;
        wait_req("t7_req", 8);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("t7_idle_valid", {31'b0, s_valid}, 32'd0);
        check("t7_idle_req", {31'b0, s_req}, 32'd0);
        wait_req("t7_req_after_reset", 8);
        check("t7_reset_addr", s_addr, RST_PC);
        repeat (6) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
